grid_wall_renderer: RTL

Parametrised maze-wall renderer for the 96x64 OLED pixel path. It replaces the fixed-coordinate wall painter. Wall geometry is held in writable segment maps, loaded through a valid/ready port and bulk-initialised by a fill state machine. Pixel coordinates stream in from the OLED driver and colour comes out two cycles later, so the output can be muxed with sprite layers in the top-level display mux.

---
 rtl/grid_wall_renderer_pkg.sv | 35 +++
 rtl/grid_wall_renderer_grid_cell_locator.sv | 59 +++++
 rtl/grid_wall_renderer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/grid_wall_renderer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : grid_wall_renderer_pkg
// Brief   : Shared display constants, fill encodings and FSM state type for
//           the maze-wall renderer.
// Rev     : 1.0  initial release
// ============================================================================
package grid_wall_renderer_pkg;

  // RGB565 colours
  localparam logic [15:0] RGB565_BLACK = 16'h0000;
  localparam logic [15:0] RGB565_WHITE = 16'hFFFF;

  // OLED panel geometry
  localparam int OLED_WIDTH  = 96;
  localparam int OLED_HEIGHT = 64;

  // fill_mode encodings
  localparam logic FILL_BORDER = 1'b0;
  localparam logic FILL_FULL   = 1'b1;

  // Bulk-fill state machine
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL_H = 2'd1,
    ST_FILL_V = 2'd2
  } fill_state_t;

  // True for the first and last index of a lattice dimension
  function automatic logic is_border(input int idx, input int last);
    return (idx == 0) || (idx == last);
  endfunction

endpackage
`default_nettype wire

// File: rtl/grid_wall_renderer_grid_cell_locator.sv
`default_nettype none
// ============================================================================
// Module  : grid_cell_locator
// Brief   : Combinational pixel -> (in_grid, cell index, in-cell offset)
//           mapping using a constant-compare chain instead of a divider.
// Rev     : 1.0  initial release
// ============================================================================
module grid_cell_locator #(
  parameter int GRID_COLS = 5,
  parameter int GRID_ROWS = 4,
  parameter int CELL_W    = 15,
  parameter int CELL_H    = 15,
  parameter int ORIGIN_X  = 11,
  parameter int ORIGIN_Y  = 2
) (
  input  logic [6:0] x,
  input  logic [6:0] y,
  output logic       in_grid,
  output logic [6:0] cx,
  output logic [6:0] ox,
  output logic [6:0] cy,
  output logic [6:0] oy
);

  // Offsets from the top-left lattice point; a pixel left of or above the
  // origin wraps to a large unsigned value and falls outside the range test.
  logic [7:0] dx;
  logic [7:0] dy;
  logic [6:0] base_x;
  logic [6:0] base_y;

  assign dx = {1'b0, x} - 8'(ORIGIN_X);
  assign dy = {1'b0, y} - 8'(ORIGIN_Y);

  // Range test plus quotient/remainder by walking the multiples of the pitch
  always_comb begin
    in_grid = (dx <= 8'(GRID_COLS * CELL_W)) && (dy <= 8'(GRID_ROWS * CELL_H));
    cx      = '0;
    base_x  = '0;
    for (int i = 1; i <= GRID_COLS; i++) begin
      if (dx >= 8'(i * CELL_W)) begin
        cx     = 7'(i);
        base_x = 7'(i * CELL_W);
      end
    end
    cy      = '0;
    base_y  = '0;
    for (int j = 1; j <= GRID_ROWS; j++) begin
      if (dy >= 8'(j * CELL_H)) begin
        cy     = 7'(j);
        base_y = 7'(j * CELL_H);
      end
    end
    ox = dx[6:0] - base_x;
    oy = dy[6:0] - base_y;
  end

endmodule
`default_nettype wire

// File: rtl/grid_wall_renderer.sv
`default_nettype none
// ============================================================================
// Module  : grid_wall_renderer
// Brief   : Maze-wall renderer for the 96x64 OLED path. Wall segments live in
//           writable H/V maps; pixels are classified in a 2-stage pipeline.
// Rev     : 1.0  initial release
// ============================================================================
module grid_wall_renderer
  import grid_wall_renderer_pkg::*;
#(
  parameter int          GRID_COLS   = 5,
  parameter int          GRID_ROWS   = 4,
  parameter int          CELL_W      = 15,
  parameter int          CELL_H      = 15,
  parameter int          ORIGIN_X    = 11,
  parameter int          ORIGIN_Y    = 2,
  parameter logic [15:0] WALL_COLOUR = RGB565_BLACK,
  parameter logic [15:0] BG_COLOUR   = RGB565_WHITE
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        pix_valid,
  input  logic [6:0]  x,
  input  logic [6:0]  y,
  output logic        oled_valid,
  output logic [15:0] oled_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic        wr_vert,
  input  logic [2:0]  wr_row,
  input  logic [2:0]  wr_col,
  input  logic        wr_bit,
  input  logic        fill_start,
  input  logic        fill_mode,
  output logic        busy
);

  localparam int RW = $clog2(GRID_ROWS + 2);
  localparam logic [GRID_COLS:0] V_BORDER =
    ((GRID_COLS + 1)'(1) << GRID_COLS) | (GRID_COLS + 1)'(1);

  // Segment maps: H has GRID_ROWS+1 lattice rows, V has GRID_ROWS cell rows
  logic [GRID_COLS-1:0] h_map [GRID_ROWS+1];
  logic [GRID_COLS:0]   v_map [GRID_ROWS];

  fill_state_t    state;
  logic [RW-1:0]  row;
  logic           mode_full;
  logic           accept;
  logic [GRID_COLS-1:0] h_fill_row;
  logic [GRID_COLS:0]   v_fill_row;

  // A fill request in the same cycle pre-empts a pending write
  assign wr_ready = !busy;
  assign accept   = wr_valid && wr_ready && !fill_start;

  // Row pattern written by the fill engine for the current row
  always_comb begin
    h_fill_row = (mode_full || is_border(int'(row), GRID_ROWS)) ? {GRID_COLS{1'b1}} : '0;
    v_fill_row = mode_full ? {(GRID_COLS + 1){1'b1}} : V_BORDER;
  end

  // Fill state machine: one H row per cycle, then one V row per cycle
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      row       <= '0;
      busy      <= 1'b0;
      mode_full <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fill_start) begin
            state     <= ST_FILL_H;
            row       <= '0;
            busy      <= 1'b1;
            mode_full <= (fill_mode == FILL_FULL);
          end
        end
        ST_FILL_H: begin
          if (row == RW'(GRID_ROWS)) begin
            state <= ST_FILL_V;
            row   <= '0;
          end else begin
            row <= row + RW'(1);
          end
        end
        ST_FILL_V: begin
          if (row == RW'(GRID_ROWS - 1)) begin
            state <= ST_IDLE;
            row   <= '0;
            busy  <= 1'b0;
          end else begin
            row <= row + RW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          row   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Map storage: reset to border, fill engine has priority over the write port
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r <= GRID_ROWS; r++) begin
        h_map[r] <= is_border(r, GRID_ROWS) ? {GRID_COLS{1'b1}} : '0;
      end
      for (int r = 0; r < GRID_ROWS; r++) begin
        v_map[r] <= V_BORDER;
      end
    end else if (state == ST_FILL_H) begin
      for (int r = 0; r <= GRID_ROWS; r++) begin
        if (row == RW'(r)) h_map[r] <= h_fill_row;
      end
    end else if (state == ST_FILL_V) begin
      for (int r = 0; r < GRID_ROWS; r++) begin
        if (row == RW'(r)) v_map[r] <= v_fill_row;
      end
    end else if (accept) begin
      // Indices outside the map match no entry and are silently dropped
      if (!wr_vert) begin
        for (int r = 0; r <= GRID_ROWS; r++) begin
          for (int c = 0; c < GRID_COLS; c++) begin
            if (wr_row == 3'(r) && wr_col == 3'(c)) h_map[r][c] <= wr_bit;
          end
        end
      end else begin
        for (int r = 0; r < GRID_ROWS; r++) begin
          for (int c = 0; c <= GRID_COLS; c++) begin
            if (wr_row == 3'(r) && wr_col == 3'(c)) v_map[r][c] <= wr_bit;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- stage 1
  logic       loc_in_grid;
  logic [6:0] loc_cx, loc_ox, loc_cy, loc_oy;

  grid_cell_locator #(
    .GRID_COLS (GRID_COLS),
    .GRID_ROWS (GRID_ROWS),
    .CELL_W    (CELL_W),
    .CELL_H    (CELL_H),
    .ORIGIN_X  (ORIGIN_X),
    .ORIGIN_Y  (ORIGIN_Y)
  ) u_locator (
    .x       (x),
    .y       (y),
    .in_grid (loc_in_grid),
    .cx      (loc_cx),
    .ox      (loc_ox),
    .cy      (loc_cy),
    .oy      (loc_oy)
  );

  logic       s1_valid;
  logic       s1_in_grid;
  logic       s1_ox_zero;
  logic       s1_oy_zero;
  logic [6:0] s1_cx;
  logic [6:0] s1_cy;

  // Stage 1: register cell indices and on-lattice flags for each pixel
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_valid   <= 1'b0;
      s1_in_grid <= 1'b0;
      s1_ox_zero <= 1'b0;
      s1_oy_zero <= 1'b0;
      s1_cx      <= '0;
      s1_cy      <= '0;
    end else begin
      s1_valid <= pix_valid;
      if (pix_valid) begin
        s1_in_grid <= loc_in_grid;
        s1_ox_zero <= (loc_ox == 7'd0);
        s1_oy_zero <= (loc_oy == 7'd0);
        s1_cx      <= loc_cx;
        s1_cy      <= loc_cy;
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic h_bit;
  logic v_bit;
  logic is_wall;

  // Map lookup against the live maps, so writes land before the S2 read
  always_comb begin
    h_bit = 1'b0;
    v_bit = 1'b0;
    for (int r = 0; r <= GRID_ROWS; r++) begin
      for (int c = 0; c < GRID_COLS; c++) begin
        if (s1_cy == 7'(r) && s1_cx == 7'(c)) h_bit = h_map[r][c];
      end
    end
    for (int r = 0; r < GRID_ROWS; r++) begin
      for (int c = 0; c <= GRID_COLS; c++) begin
        if (s1_cy == 7'(r) && s1_cx == 7'(c)) v_bit = v_map[r][c];
      end
    end
    is_wall = s1_in_grid &&
              ((s1_ox_zero && s1_oy_zero) ||
               (s1_oy_zero && h_bit) ||
               (s1_ox_zero && v_bit));
  end

  // Stage 2: register colour; hold the last colour on idle cycles
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      oled_valid <= 1'b0;
      oled_data  <= '0;
    end else begin
      oled_valid <= s1_valid;
      if (s1_valid) oled_data <= is_wall ? WALL_COLOUR : BG_COLOUR;
    end
  end

endmodule
`default_nettype wire
